// File: rtl/quad_encoder_bank.sv
// rtl/quad_encoder_bank.sv - bank of filtered 4x quadrature decoders with windowed speed
module quad_encoder_bank #(
    parameter int N_CH   = 3,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 32,
    parameter int WINDOW = 500000,
    parameter int FILT   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         enc_a,
    input  logic [N_CH-1:0]         enc_b,
    input  logic [N_CH-1:0]         pos_clr,
    input  logic                    err_clr,
    output logic [N_CH*CNT_W-1:0]   position,
    output logic [N_CH*CNT_W-1:0]   speed,
    output logic [N_CH-1:0]         dir,
    output logic [N_CH-1:0]         err,
    output logic                    window_tick
);

    localparam int NL   = 2 * N_CH;
    localparam int FC_W = (FILT > 1) ? $clog2(FILT) : 1;

    // Lines are handled as one vector: A lines in the low half, B lines in the high half.
    logic [NL-1:0]   sync1, sync2, filt, filt_prev;
    logic [FC_W-1:0] fcnt [NL];
    logic [1:0]      boot_cnt;
    logic [N_CH-1:0] prime;
    logic            load;

    logic [CNT_W-1:0] pos_r [N_CH];
    logic [CNT_W-1:0] acc_r [N_CH];
    logic [CNT_W-1:0] spd_r [N_CH];
    logic [WIN_W-1:0] wcnt;
    logic             wrap;

    logic [N_CH-1:0] step_fwd, step_rev, illegal;

    assign load = (boot_cnt == 2'd2);
    assign wrap = (wcnt == WIN_W'(WINDOW - 1));

    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] a,
                                                  input logic up, input logic dn);
        logic [CNT_W:0] s;
        s = {a[CNT_W-1], a};
        if (up)
            s = s + {{CNT_W{1'b0}}, 1'b1};
        else if (dn)
            s = s - {{CNT_W{1'b0}}, 1'b1};
        if (s[CNT_W] != s[CNT_W-1])
            return s[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
        return s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            filt      <= '0;
            filt_prev <= '0;
            boot_cnt  <= '0;
            prime     <= '0;
            for (int j = 0; j < NL; j++)
                fcnt[j] <= '0;
        end else begin
            sync1 <= {enc_b, enc_a};
            sync2 <= sync1;
            if (boot_cnt != 2'd3)
                boot_cnt <= boot_cnt + 2'd1;
            prime     <= prime | {N_CH{load}};
            // Priming takes the synchronised level as-is so a line idling high is not a step.
            filt_prev <= load ? sync2 : filt;
            for (int j = 0; j < NL; j++) begin
                if (load) begin
                    filt[j] <= sync2[j];
                    fcnt[j] <= '0;
                end else if (sync2[j] == filt[j]) begin
                    fcnt[j] <= '0;
                end else if (fcnt[j] == FC_W'(FILT - 1)) begin
                    filt[j] <= sync2[j];
                    fcnt[j] <= '0;
                end else begin
                    fcnt[j] <= fcnt[j] + 1'b1;
                end
            end
        end
    end

    // Gray position index: 00->0, 10->1, 11->2, 01->3; index delta gives the step.
    always_comb begin
        step_fwd = '0;
        step_rev = '0;
        illegal  = '0;
        for (int i = 0; i < N_CH; i++) begin
            logic [1:0] pidx, cidx, d;
            pidx = {filt_prev[N_CH+i], filt_prev[N_CH+i] ^ filt_prev[i]};
            cidx = {filt[N_CH+i], filt[N_CH+i] ^ filt[i]};
            d    = cidx - pidx;
            step_fwd[i] = prime[i] && (d == 2'd1);
            step_rev[i] = prime[i] && (d == 2'd3);
            illegal[i]  = prime[i] && (d == 2'd2);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt        <= '0;
            window_tick <= 1'b0;
            dir         <= '0;
            err         <= '0;
            for (int i = 0; i < N_CH; i++) begin
                pos_r[i] <= '0;
                acc_r[i] <= '0;
                spd_r[i] <= '0;
            end
        end else begin
            wcnt        <= wrap ? '0 : wcnt + 1'b1;
            window_tick <= wrap;
            for (int i = 0; i < N_CH; i++) begin
                if (pos_clr[i])
                    pos_r[i] <= '0;
                else if (step_fwd[i])
                    pos_r[i] <= pos_r[i] + 1'b1;
                else if (step_rev[i])
                    pos_r[i] <= pos_r[i] - 1'b1;

                if (wrap) begin
                    spd_r[i] <= sat_step(acc_r[i], step_fwd[i], step_rev[i]);
                    acc_r[i] <= '0;
                end else begin
                    acc_r[i] <= sat_step(acc_r[i], step_fwd[i], step_rev[i]);
                end

                if (step_fwd[i] || step_rev[i])
                    dir[i] <= step_fwd[i];

                if (illegal[i])
                    err[i] <= 1'b1;
                else if (err_clr)
                    err[i] <= 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_pack
            assign position[g*CNT_W +: CNT_W] = pos_r[g];
            assign speed[g*CNT_W +: CNT_W]    = spd_r[g];
        end
    endgenerate

endmodule
